// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux8
//  Description : Receive end of an 8:1 time-division mux link. Acquires slot
//                alignment from a sync marker, steers each beat into its slot
//                register and presents the rebuilt frame in parallel with a
//                one-cycle frame-valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux8 #(
    parameter int WIDTH = 1,
    parameter int SLOTS = 8,
    parameter int SEL_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     sync,
    input  logic [WIDTH-1:0]         din,
    output logic [SLOTS*WIDTH-1:0]   dout,
    output logic                     dout_valid,
    output logic [SEL_W-1:0]         slot,
    output logic                     locked,
    output logic                     sync_err
);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] c_slot_zero = '0;
    localparam logic [SEL_W-1:0] c_slot_one  = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_slot_last = SEL_W'(SLOTS - 1);

    state_t                   r_state;
    logic [SEL_W-1:0]         r_slot;
    logic [WIDTH-1:0]         r_shadow [SLOTS];
    logic [SLOTS*WIDTH-1:0]   r_dout;
    logic                     r_dout_valid;
    logic                     r_sync_err;
    logic [SLOTS*WIDTH-1:0]   w_frame;

    // Frame as it would look if the current beat completes it: stored slots
    // 0..SLOTS-2 with the incoming beat in the top slot.
    generate
        for (genvar n = 0; n < SLOTS; n++) begin : g_pack
            if (n == SLOTS - 1) begin : g_top
                assign w_frame[n*WIDTH +: WIDTH] = din;
            end else begin : g_low
                assign w_frame[n*WIDTH +: WIDTH] = r_shadow[n];
            end
        end
    endgenerate

    // Alignment FSM, slot steering, frame publish and error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_slot       <= c_slot_zero;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_dout_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    S_HUNT: begin
                        // Beats before the first sync carry no alignment and are dropped.
                        if (sync) begin
                            r_shadow[0] <= din;
                            r_slot      <= c_slot_one;
                            r_state     <= S_LOCK;
                        end
                    end
                    S_LOCK: begin
                        if (sync && (r_slot != c_slot_zero)) begin
                            // Misplaced sync: abandon the partial frame and realign on this beat.
                            r_shadow[0] <= din;
                            r_slot      <= c_slot_one;
                            r_sync_err  <= 1'b1;
                        end else begin
                            r_shadow[r_slot] <= din;
                            r_slot           <= r_slot + c_slot_one;
                            if (r_slot == c_slot_last) begin
                                r_dout       <= w_frame;
                                r_dout_valid <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign slot       = r_slot;
    assign locked     = (r_state == S_LOCK);
    assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux8
//  Description : Self-checking bench for tdm_demux8 (WIDTH=1, SLOTS=8):
//                directed vector table plus a back-to-back frame sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_demux8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       sync;
    logic [0:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;

    tdm_demux8 #(.WIDTH(1), .SLOTS(8), .SEL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sync       (sync),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic       sync;
        logic       din;
        logic [7:0] e_dout;
        logic       e_dv;
        logic [2:0] e_slot;
        logic       e_locked;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic iv, input logic s, input logic d,
                       input logic [7:0] ed, input logic edv, input logic [2:0] es,
                       input logic el, input logic ee);
        vec_t v;
        v.rst = r; v.iv = iv; v.sync = s; v.din = d;
        v.e_dout = ed; v.e_dv = edv; v.e_slot = es; v.e_locked = el; v.e_err = ee;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare all outputs.
    task automatic step(input string name, input logic r, input logic iv, input logic s,
                        input logic d, input logic [7:0] ed, input logic edv,
                        input logic [2:0] es, input logic el, input logic ee);
        rst = r; in_valid = iv; sync = s; din = d;
        @(posedge clk);
        #1;
        n_vec++;
        if (dout !== ed || dout_valid !== edv || slot !== es || locked !== el || sync_err !== ee) begin
            n_miss++;
            $display("FAIL %s: got dout=%h dv=%b slot=%0d locked=%b err=%b, want dout=%h dv=%b slot=%0d locked=%b err=%b",
                     name, dout, dout_valid, slot, locked, sync_err, ed, edv, es, el, ee);
        end
    endtask

    logic [15:0] bits;
    logic [7:0]  exp_frame;
    logic [7:0]  last_frame;
    logic [2:0]  exp_slot;

    initial begin
        rst = 1'b1; in_valid = 1'b0; sync = 1'b0; din = 1'b0;

        // reset, two cycles
        add(1,0,0,0, 8'h00,0,3'd0,0,0);
        add(1,0,0,0, 8'h00,0,3'd0,0,0);
        // HUNT drops non-sync beats
        for (int i = 0; i < 5; i++) add(0,1,0,1, 8'h00,0,3'd0,0,0);
        // sync acquires: slot 0 = 1
        add(0,1,1,1, 8'h00,0,3'd1,1,0);
        // rest of frame, slots 1..7 = 0,1,1,0,0,1,0 -> 8'b0100_1101
        add(0,1,0,0, 8'h00,0,3'd2,1,0);
        add(0,1,0,1, 8'h00,0,3'd3,1,0);
        add(0,1,0,1, 8'h00,0,3'd4,1,0);
        add(0,1,0,0, 8'h00,0,3'd5,1,0);
        add(0,1,0,0, 8'h00,0,3'd6,1,0);
        add(0,1,0,1, 8'h00,0,3'd7,1,0);
        add(0,1,0,0, 8'h4D,1,3'd0,1,0);
        add(0,0,0,0, 8'h4D,0,3'd0,1,0);
        // same frame, in_valid toggling; idle cycles carry sync=1/din=1 that must be ignored
        add(0,1,0,1, 8'h4D,0,3'd1,1,0);  add(0,0,1,1, 8'h4D,0,3'd1,1,0);
        add(0,1,0,0, 8'h4D,0,3'd2,1,0);  add(0,0,1,1, 8'h4D,0,3'd2,1,0);
        add(0,1,0,1, 8'h4D,0,3'd3,1,0);  add(0,0,1,1, 8'h4D,0,3'd3,1,0);
        add(0,1,0,1, 8'h4D,0,3'd4,1,0);  add(0,0,1,1, 8'h4D,0,3'd4,1,0);
        add(0,1,0,0, 8'h4D,0,3'd5,1,0);  add(0,0,1,1, 8'h4D,0,3'd5,1,0);
        add(0,1,0,0, 8'h4D,0,3'd6,1,0);  add(0,0,1,1, 8'h4D,0,3'd6,1,0);
        add(0,1,0,1, 8'h4D,0,3'd7,1,0);  add(0,0,1,1, 8'h4D,0,3'd7,1,0);
        add(0,1,0,0, 8'h4D,1,3'd0,1,0);  add(0,0,1,1, 8'h4D,0,3'd0,1,0);
        // slots 0..4 = 1, then misplaced sync at slot 5 (din=0 becomes new slot 0)
        add(0,1,0,1, 8'h4D,0,3'd1,1,0);
        add(0,1,0,1, 8'h4D,0,3'd2,1,0);
        add(0,1,0,1, 8'h4D,0,3'd3,1,0);
        add(0,1,0,1, 8'h4D,0,3'd4,1,0);
        add(0,1,0,1, 8'h4D,0,3'd5,1,0);
        add(0,1,1,0, 8'h4D,0,3'd1,1,1);
        // slots 1..7 = 1 complete the realigned frame -> 8'hFE
        add(0,1,0,1, 8'h4D,0,3'd2,1,0);
        add(0,1,0,1, 8'h4D,0,3'd3,1,0);
        add(0,1,0,1, 8'h4D,0,3'd4,1,0);
        add(0,1,0,1, 8'h4D,0,3'd5,1,0);
        add(0,1,0,1, 8'h4D,0,3'd6,1,0);
        add(0,1,0,1, 8'h4D,0,3'd7,1,0);
        add(0,1,0,1, 8'hFE,1,3'd0,1,0);
        // sync at slot 0 while locked is a normal beat
        add(0,1,1,1, 8'hFE,0,3'd1,1,0);
        // advance to slot 4, then reset mid-frame with a beat present
        add(0,1,0,0, 8'hFE,0,3'd2,1,0);
        add(0,1,0,0, 8'hFE,0,3'd3,1,0);
        add(0,1,0,0, 8'hFE,0,3'd4,1,0);
        add(1,1,0,1, 8'h00,0,3'd0,0,0);
        // back in HUNT: non-sync beat dropped
        add(0,1,0,1, 8'h00,0,3'd0,0,0);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].iv, vecs[i].sync, vecs[i].din,
                 vecs[i].e_dout, vecs[i].e_dv, vecs[i].e_slot, vecs[i].e_locked, vecs[i].e_err);
        end

        // Back-to-back frames with in_valid held high: strobes every 8 beats.
        bits       = 16'($urandom());
        last_frame = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_slot = 3'((i + 1) % 8);
            if (i % 8 == 7) begin
                for (int k = 0; k < 8; k++) exp_frame[k] = bits[(i - 7) + k];
                last_frame = exp_frame;
                step($sformatf("b2b_beat%0d", i), 0, 1, (i == 0), bits[i],
                     exp_frame, 1, exp_slot, 1, 0);
            end else begin
                step($sformatf("b2b_beat%0d", i), 0, 1, (i == 0), bits[i],
                     last_frame, 0, exp_slot, 1, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
